mem_lsu: RTL and testbench

Memory-access stage of the RV32I pipeline, between the EX/MEM pipeline register and the MEM/WB register. It turns load/store requests into transactions on a request/grant/response data bus. It builds byte enables and lane-replicated store data, and aligns and sign/zero-extends load data. It stalls the upstream pipeline while a data-bus access is outstanding and presents a bubble downstream until the access completes.

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/load_align.sv | 40 ++++
 rtl/mem_lsu.sv | 170 +++++++++++++++++
 tb/tb_mem_lsu.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lsu_pkg                                                      |
// | Description : Shared types, funct3 codes and access-size helper for the    |
// |               memory-access stage.                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_t;

    localparam logic [2:0] c_f3_lb  = 3'b000;
    localparam logic [2:0] c_f3_lh  = 3'b001;
    localparam logic [2:0] c_f3_lw  = 3'b010;
    localparam logic [2:0] c_f3_lbu = 3'b100;
    localparam logic [2:0] c_f3_lhu = 3'b101;
    localparam logic [2:0] c_f3_sb  = 3'b000;
    localparam logic [2:0] c_f3_sh  = 3'b001;
    localparam logic [2:0] c_f3_sw  = 3'b010;

    // Unlisted funct3 codes (3, 6, 7) fall through to a full-word access.
    function automatic lsu_size_t access_size(input logic [2:0] funct3);
        lsu_size_t size;
        case (funct3)
            c_f3_lb, c_f3_lbu: size = SZ_BYTE;
            c_f3_lh, c_f3_lhu: size = SZ_HALF;
            default:           size = SZ_WORD;
        endcase
        return size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : load_align                                                   |
// | Description : Selects the addressed byte/half of a read word and extends   |
// |               it to 32 bits.                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_signed;

    always_comb begin
        w_byte   = 8'h00;
        w_half   = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        w_signed = (i_funct3 == c_f3_lb) || (i_funct3 == c_f3_lh);
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase

        case (access_size(i_funct3))
            SZ_BYTE: o_data = {{24{w_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{w_signed & w_half[15]}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_lsu                                                      |
// | Description : RV32I memory-access stage: data-bus sequencing, store lanes, |
// |               load alignment and pipeline stall generation.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        rd_addr_i,
    input  logic [31:0]       rd_data_i,
    input  logic              rd_wen_i,
    input  logic              mem_re_i,
    input  logic              mem_we_i,
    input  logic [2:0]        mem_funct3_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              dbus_req_o,
    output logic              dbus_we_o,
    output logic [ADDR_W-1:0] dbus_addr_o,
    output logic [3:0]        dbus_be_o,
    output logic [31:0]       dbus_wdata_o,
    input  logic              dbus_gnt_i,
    input  logic              dbus_rvalid_i,
    input  logic [31:0]       dbus_rdata_i,
    output logic              stall_o,
    output logic              misalign_o,
    output logic [4:0]        rd_addr_o,
    output logic [31:0]       rd_data_o,
    output logic              rd_wen_o,
    output logic              mem_re_o,
    output logic [31:0]       ram_data_o
);

    lsu_state_t r_state;
    lsu_state_t w_state_nxt;
    logic [31:0] r_rdata;

    lsu_size_t   w_size;
    logic        w_is_mem;
    logic        w_is_load;
    logic        w_misalign;
    logic        w_req;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_word;

    load_align u_load_align (
        .i_funct3  (mem_funct3_i),
        .i_addr_lo (mem_addr_i[1:0]),
        .i_rdata   (dbus_rdata_i),
        .o_data    (w_load_word)
    );

    // A simultaneous read/write request is treated as a load.
    assign w_is_mem   = mem_re_i | mem_we_i;
    assign w_is_load  = mem_re_i;
    assign w_size     = access_size(mem_funct3_i);
    assign w_misalign = ((w_size == SZ_HALF) && mem_addr_i[0]) ||
                        ((w_size == SZ_WORD) && (mem_addr_i[1:0] != 2'b00));

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = mem_wdata_i;
        case (w_size)
            SZ_BYTE: begin
                w_be    = 4'b0001 << mem_addr_i[1:0];
                w_wdata = {4{mem_wdata_i[7:0]}};
            end
            SZ_HALF: begin
                w_be    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{mem_wdata_i[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = mem_wdata_i;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_rdata <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_RESP) && dbus_rvalid_i) begin
                r_rdata <= w_load_word;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_req        = 1'b0;
        stall_o      = 1'b0;
        misalign_o   = 1'b0;
        rd_addr_o    = rd_addr_i;
        rd_data_o    = rd_data_i;
        rd_wen_o     = 1'b0;
        mem_re_o     = 1'b0;
        ram_data_o   = 32'h0;

        case (r_state)
            ST_IDLE: begin
                if (!w_is_mem) begin
                    rd_wen_o = rd_wen_i;
                    mem_re_o = mem_re_i;
                end else if (w_misalign) begin
                    misalign_o = 1'b1;
                end else begin
                    w_req = 1'b1;
                    if (w_is_load) begin
                        stall_o     = 1'b1;
                        w_state_nxt = dbus_gnt_i ? ST_RESP : ST_REQ;
                    end else if (dbus_gnt_i) begin
                        rd_wen_o = rd_wen_i;
                    end else begin
                        stall_o     = 1'b1;
                        w_state_nxt = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                w_req   = 1'b1;
                stall_o = 1'b1;
                if (dbus_gnt_i) begin
                    w_state_nxt = w_is_load ? ST_RESP : ST_DONE;
                end
            end
            ST_RESP: begin
                stall_o = 1'b1;
                if (dbus_rvalid_i) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                ram_data_o  = r_rdata;
                rd_wen_o    = rd_wen_i;
                mem_re_o    = mem_re_i;
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Outputs are combinational, so reset has to mask them directly.
        if (!rst) begin
            w_req      = 1'b0;
            stall_o    = 1'b0;
            misalign_o = 1'b0;
            rd_addr_o  = 5'h0;
            rd_data_o  = 32'h0;
            rd_wen_o   = 1'b0;
            mem_re_o   = 1'b0;
            ram_data_o = 32'h0;
        end

        dbus_req_o   = w_req;
        dbus_we_o    = w_req & ~w_is_load;
        dbus_addr_o  = w_req ? {mem_addr_i[ADDR_W-1:2], 2'b00} : '0;
        dbus_be_o    = w_req ? w_be : 4'b0000;
        dbus_wdata_o = w_req ? w_wdata : 32'h0;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_lsu                                                   |
// | Description : Directed self-checking bench for mem_lsu.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_lsu;

    logic        clk;
    logic        rst;
    logic [4:0]  rd_addr_i;
    logic [31:0] rd_data_i;
    logic        rd_wen_i;
    logic        mem_re_i;
    logic        mem_we_i;
    logic [2:0]  mem_funct3_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_gnt_i;
    logic        dbus_rvalid_i;
    logic [31:0] dbus_rdata_i;
    logic        stall_o;
    logic        misalign_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        rd_wen_o;
    logic        mem_re_o;
    logic [31:0] ram_data_o;

    int n_tests = 0;
    int n_fail  = 0;
    int n_stall;
    int n_wen;
    int n_req;

    mem_lsu #(.ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .rd_addr_i     (rd_addr_i),
        .rd_data_i     (rd_data_i),
        .rd_wen_i      (rd_wen_i),
        .mem_re_i      (mem_re_i),
        .mem_we_i      (mem_we_i),
        .mem_funct3_i  (mem_funct3_i),
        .mem_addr_i    (mem_addr_i),
        .mem_wdata_i   (mem_wdata_i),
        .dbus_req_o    (dbus_req_o),
        .dbus_we_o     (dbus_we_o),
        .dbus_addr_o   (dbus_addr_o),
        .dbus_be_o     (dbus_be_o),
        .dbus_wdata_o  (dbus_wdata_o),
        .dbus_gnt_i    (dbus_gnt_i),
        .dbus_rvalid_i (dbus_rvalid_i),
        .dbus_rdata_i  (dbus_rdata_i),
        .stall_o       (stall_o),
        .misalign_o    (misalign_o),
        .rd_addr_o     (rd_addr_o),
        .rd_data_o     (rd_data_o),
        .rd_wen_o      (rd_wen_o),
        .mem_re_o      (mem_re_o),
        .ram_data_o    (ram_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic re, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [4:0] rd, input logic [31:0] rdat, input logic wen);
        mem_re_i     = re;
        mem_we_i     = we;
        mem_funct3_i = f3;
        mem_addr_i   = addr;
        mem_wdata_i  = wdata;
        rd_addr_i    = rd;
        rd_data_i    = rdat;
        rd_wen_i     = wen;
    endtask

    initial begin
        rst           = 1'b0;
        dbus_gnt_i    = 1'b1;
        dbus_rvalid_i = 1'b0;
        dbus_rdata_i  = 32'h0;
        set_instr(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 5'd5, 32'h1234, 1'b1);

        // Reset: every output held at zero despite an active load on the inputs
        @(negedge clk);
        chk("rst_req",   {31'h0, dbus_req_o}, 32'h0);
        chk("rst_stall", {31'h0, stall_o},    32'h0);
        chk("rst_wen",   {31'h0, rd_wen_o},   32'h0);
        chk("rst_data",  rd_data_o,           32'h0);
        chk("rst_rd",    {27'h0, rd_addr_o},  32'h0);
        chk("rst_baddr", dbus_addr_o,         32'h0);
        tick();
        tick();
        rst = 1'b1;

        // Pass-through of an ALU result
        dbus_gnt_i = 1'b0;
        set_instr(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd5, 32'h1234, 1'b1);
        @(negedge clk);
        chk("pt_rd",    {27'h0, rd_addr_o},  32'd5);
        chk("pt_data",  rd_data_o,           32'h1234);
        chk("pt_wen",   {31'h0, rd_wen_o},   32'h1);
        chk("pt_stall", {31'h0, stall_o},    32'h0);
        chk("pt_req",   {31'h0, dbus_req_o}, 32'h0);
        tick();

        // LB at 0x103, grant in cycle 0, rvalid in cycle 1
        set_instr(1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 5'd7, 32'h55, 1'b1);
        dbus_gnt_i = 1'b1;
        @(negedge clk);
        chk("lb_c0_stall", {31'h0, stall_o},    32'h1);
        chk("lb_c0_req",   {31'h0, dbus_req_o}, 32'h1);
        chk("lb_c0_we",    {31'h0, dbus_we_o},  32'h0);
        chk("lb_c0_addr",  dbus_addr_o,         32'h100);
        chk("lb_c0_be",    {28'h0, dbus_be_o},  32'h8);
        chk("lb_c0_wen",   {31'h0, rd_wen_o},   32'h0);
        tick();
        dbus_gnt_i    = 1'b0;
        dbus_rvalid_i = 1'b1;
        dbus_rdata_i  = 32'h80FF_0000;
        @(negedge clk);
        chk("lb_c1_stall", {31'h0, stall_o},    32'h1);
        chk("lb_c1_req",   {31'h0, dbus_req_o}, 32'h0);
        chk("lb_c1_mre",   {31'h0, mem_re_o},   32'h0);
        tick();
        dbus_rvalid_i = 1'b0;
        dbus_rdata_i  = 32'h0;
        @(negedge clk);
        chk("lb_c2_stall", {31'h0, stall_o},  32'h0);
        chk("lb_c2_data",  ram_data_o,        32'hFFFF_FF80);
        chk("lb_c2_mre",   {31'h0, mem_re_o}, 32'h1);
        chk("lb_c2_wen",   {31'h0, rd_wen_o}, 32'h1);
        chk("lb_c2_rd",    {27'h0, rd_addr_o}, 32'd7);
        tick();

        // LHU at 0x102, grant three cycles late, rvalid right after grant
        set_instr(1'b1, 1'b0, 3'd5, 32'h102, 32'h0, 5'd9, 32'h0, 1'b1);
        n_stall = 0;
        n_wen   = 0;
        n_req   = 0;
        for (int c = 0; c < 5; c++) begin
            dbus_gnt_i    = (c == 3);
            dbus_rvalid_i = (c == 4);
            dbus_rdata_i  = (c == 4) ? 32'hBEEF_0000 : 32'h1111_2222;
            @(negedge clk);
            if (stall_o) n_stall++;
            if (rd_wen_o) n_wen++;
            if (dbus_req_o && dbus_addr_o == 32'h100 && dbus_be_o == 4'b1100) n_req++;
            tick();
        end
        dbus_gnt_i    = 1'b0;
        dbus_rvalid_i = 1'b0;
        @(negedge clk);
        chk("lhu_stall_cycles", n_stall,           32'd5);
        chk("lhu_wen_early",    n_wen,             32'd0);
        chk("lhu_req_cycles",   n_req,             32'd4);
        chk("lhu_done_stall",   {31'h0, stall_o},  32'h0);
        chk("lhu_done_data",    ram_data_o,        32'h0000_BEEF);
        chk("lhu_done_wen",     {31'h0, rd_wen_o}, 32'h1);
        tick();

        // SB at 0x201 with immediate grant
        set_instr(1'b0, 1'b1, 3'd0, 32'h201, 32'h1234_56AB, 5'd0, 32'h0, 1'b0);
        dbus_gnt_i = 1'b1;
        @(negedge clk);
        chk("sb_be",    {28'h0, dbus_be_o}, 32'h2);
        chk("sb_wdata", dbus_wdata_o,       32'hABAB_ABAB);
        chk("sb_addr",  dbus_addr_o,        32'h200);
        chk("sb_we",    {31'h0, dbus_we_o}, 32'h1);
        chk("sb_stall", {31'h0, stall_o},   32'h0);
        tick();

        // SH at 0x202 with a one-cycle grant delay
        set_instr(1'b0, 1'b1, 3'd1, 32'h202, 32'h0000_CAFE, 5'd0, 32'h0, 1'b0);
        dbus_gnt_i = 1'b0;
        @(negedge clk);
        chk("sh_be",    {28'h0, dbus_be_o}, 32'hC);
        chk("sh_wdata", dbus_wdata_o,       32'hCAFE_CAFE);
        chk("sh_stall0", {31'h0, stall_o},  32'h1);
        tick();
        dbus_gnt_i = 1'b1;
        @(negedge clk);
        chk("sh_stall1", {31'h0, stall_o},   32'h1);
        chk("sh_req1",   {31'h0, dbus_req_o}, 32'h1);
        tick();
        dbus_gnt_i = 1'b0;
        @(negedge clk);
        chk("sh_done_stall", {31'h0, stall_o},    32'h0);
        chk("sh_done_req",   {31'h0, dbus_req_o}, 32'h0);
        tick();

        // Misaligned LW at 0x302: single pulse, no bus access
        set_instr(1'b1, 1'b0, 3'd2, 32'h302, 32'h0, 5'd3, 32'h77, 1'b1);
        dbus_gnt_i = 1'b1;
        @(negedge clk);
        chk("mis_flag",  {31'h0, misalign_o}, 32'h1);
        chk("mis_req",   {31'h0, dbus_req_o}, 32'h0);
        chk("mis_wen",   {31'h0, rd_wen_o},   32'h0);
        chk("mis_stall", {31'h0, stall_o},    32'h0);
        chk("mis_mre",   {31'h0, mem_re_o},   32'h0);
        tick();
        set_instr(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd4, 32'h99, 1'b1);
        @(negedge clk);
        chk("mis_next_flag", {31'h0, misalign_o}, 32'h0);
        chk("mis_next_wen",  {31'h0, rd_wen_o},   32'h1);
        tick();

        // Reset while waiting in RESP, then a stray rvalid
        set_instr(1'b1, 1'b0, 3'd2, 32'h400, 32'h0, 5'd6, 32'h42, 1'b1);
        dbus_gnt_i = 1'b1;
        @(negedge clk);
        chk("rr_req0", {31'h0, dbus_req_o}, 32'h1);
        tick();
        dbus_gnt_i = 1'b0;
        rst        = 1'b0;
        @(negedge clk);
        chk("rr_rst_stall", {31'h0, stall_o},   32'h0);
        chk("rr_rst_wen",   {31'h0, rd_wen_o},  32'h0);
        chk("rr_rst_data",  rd_data_o,          32'h0);
        chk("rr_rst_ram",   ram_data_o,         32'h0);
        tick();
        rst           = 1'b1;
        dbus_rvalid_i = 1'b1;
        dbus_rdata_i  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rr_idle_req",  {31'h0, dbus_req_o}, 32'h1);
        chk("rr_idle_wen",  {31'h0, rd_wen_o},   32'h0);
        tick();
        dbus_rvalid_i = 1'b0;
        @(negedge clk);
        chk("rr_after_wen", {31'h0, rd_wen_o},   32'h0);
        chk("rr_after_req", {31'h0, dbus_req_o}, 32'h1);
        chk("rr_after_ram", ram_data_o,          32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
